// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequencer (wait, precharge-all, N auto-refreshes, mode load) followed by a
// periodic auto-refresh scheduler that borrows the command bus via a req/ack handshake.
module sdram_init_refresh_ctrl #(
  parameter int unsigned CLK_MHZ          = 100,
  parameter int unsigned INIT_WAIT_US     = 200,
  parameter int unsigned INIT_REFRESH     = 8,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RC             = 7,
  parameter int unsigned T_MRD            = 2,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter logic [2:0]  BURST_CODE       = 3'b001,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned REFRESH_BACKLOG  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_ack,
  output logic        own_bus,
  output logic        ref_overrun,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM
);

  localparam int unsigned WaitCycles = CLK_MHZ * INIT_WAIT_US;
  localparam int unsigned PwW  = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam int unsigned MaxA = (T_RP > T_RC) ? T_RP : T_RC;
  localparam int unsigned MaxT = (MaxA > T_MRD) ? MaxA : T_MRD;
  localparam int unsigned GapW = (MaxT > 1) ? $clog2(MaxT) : 1;
  localparam int unsigned IrW  = (INIT_REFRESH > 1) ? $clog2(INIT_REFRESH) : 1;
  localparam int unsigned TmW  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned PdW  = $clog2(REFRESH_BACKLOG + 1);

  localparam logic [PwW-1:0]  PwLast  = PwW'(WaitCycles);
  localparam logic [GapW-1:0] GapRp   = GapW'(T_RP - 1);
  localparam logic [GapW-1:0] GapRc   = GapW'(T_RC - 1);
  localparam logic [GapW-1:0] GapMrd  = GapW'(T_MRD - 1);
  localparam logic [IrW-1:0]  IrLast  = IrW'(INIT_REFRESH - 1);
  localparam logic [TmW-1:0]  TmLast  = TmW'(REFRESH_INTERVAL - 1);
  localparam logic [PdW-1:0]  PendMax = PdW'(REFRESH_BACKLOG);
  localparam logic [2:0]      CasBits = 3'(CAS_LATENCY);

  localparam logic [12:0] AddrPreAll = 13'h0400;
  localparam logic [12:0] AddrMode   = {6'b0, CasBits, 1'b0, BURST_CODE};

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  typedef enum logic [3:0] {
    StPowerWait, StPrecharge, StPreWait, StInitRef, StInitRefWait,
    StMode, StModeWait, StIdle, StPref, StPrefWait
  } state_e;

  state_e          state_q;
  logic [PwW-1:0]  pw_cnt_q;
  logic [GapW-1:0] gap_q;
  logic [IrW-1:0]  ir_cnt_q;
  logic [TmW-1:0]  tmr_q, tmr_d;
  logic [PdW-1:0]  pend_q, pend_d;
  logic [3:0]      cmd_q;
  logic            dqm_q;
  logic            active, issue, tick, overrun_set, to_idle, ref_req_d;

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
  assign DRAM_BA   = 2'b00;
  assign DRAM_LDQM = dqm_q;
  assign DRAM_UDQM = dqm_q;

  // Refresh bookkeeping only runs once init is complete.
  always_comb begin
    active      = (state_q == StIdle) || (state_q == StPref) || (state_q == StPrefWait);
    issue       = (state_q == StIdle) && ref_req && ref_ack;
    tick        = active && (tmr_q == TmLast);
    pend_d      = pend_q;
    overrun_set = 1'b0;
    if (tick && !issue) begin
      if (pend_q == PendMax) overrun_set = 1'b1;
      else                   pend_d = pend_q + 1'b1;
    end else if (issue && !tick) begin
      pend_d = pend_q - 1'b1;
    end
    if (!active || tick) tmr_d = '0;
    else                 tmr_d = tmr_q + 1'b1;
    to_idle   = ((state_q == StIdle) && !issue) ||
                (((state_q == StPref) || (state_q == StPrefWait)) && (gap_q == '0));
    ref_req_d = to_idle && (pend_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPowerWait;
      pw_cnt_q    <= '0;
      gap_q       <= '0;
      ir_cnt_q    <= '0;
      tmr_q       <= '0;
      pend_q      <= '0;
      cmd_q       <= CmdNop;
      DRAM_ADDR   <= '0;
      dqm_q       <= 1'b1;
      init_done   <= 1'b0;
      ref_req     <= 1'b0;
      own_bus     <= 1'b1;
      ref_overrun <= 1'b0;
    end else begin
      cmd_q       <= CmdNop;
      DRAM_ADDR   <= '0;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      ref_req     <= ref_req_d;
      ref_overrun <= ref_overrun | overrun_set;
      case (state_q)
        StPowerWait: begin
          if (pw_cnt_q == PwLast) begin
            state_q   <= StPrecharge;
            cmd_q     <= CmdPre;
            DRAM_ADDR <= AddrPreAll;
            gap_q     <= GapRp;
          end else begin
            pw_cnt_q <= pw_cnt_q + 1'b1;
          end
        end
        StPrecharge, StPreWait: begin
          if (gap_q == '0) begin
            state_q  <= StInitRef;
            cmd_q    <= CmdRef;
            gap_q    <= GapRc;
            ir_cnt_q <= '0;
          end else begin
            state_q <= StPreWait;
            gap_q   <= gap_q - 1'b1;
          end
        end
        StInitRef, StInitRefWait: begin
          if (gap_q != '0) begin
            state_q <= StInitRefWait;
            gap_q   <= gap_q - 1'b1;
          end else if (ir_cnt_q == IrLast) begin
            state_q   <= StMode;
            cmd_q     <= CmdMrs;
            DRAM_ADDR <= AddrMode;
            gap_q     <= GapMrd;
          end else begin
            state_q  <= StInitRef;
            cmd_q    <= CmdRef;
            gap_q    <= GapRc;
            ir_cnt_q <= ir_cnt_q + 1'b1;
          end
        end
        StMode, StModeWait: begin
          if (gap_q == '0) begin
            state_q   <= StIdle;
            init_done <= 1'b1;
            own_bus   <= 1'b0;
            dqm_q     <= 1'b0;
          end else begin
            state_q <= StModeWait;
            gap_q   <= gap_q - 1'b1;
          end
        end
        StIdle: begin
          if (issue) begin
            state_q <= StPref;
            cmd_q   <= CmdRef;
            gap_q   <= GapRc;
            own_bus <= 1'b1;
          end
        end
        StPref, StPrefWait: begin
          if (gap_q == '0) begin
            state_q <= StIdle;
            own_bus <= 1'b0;
          end else begin
            state_q <= StPrefWait;
            gap_q   <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q   <= StPowerWait;
          pw_cnt_q  <= '0;
          init_done <= 1'b0;
          own_bus   <= 1'b1;
          dqm_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule
